grid_scan_reader: RTL and testbench
===================================

Name: grid_scan_reader

Overview:
- Display-side reader of the Tetris playfield buffer; the CPU writes cells on one side, this block reads them out.
- Takes the flattened grid bus and a pixel coordinate stream from the VGA timing logic.
- Returns the colour index of the cell under each pixel, plus an in-grid flag and a border flag, with fixed 2-cycle latency.
- Snapshots the grid at frame start so CPU writes mid-frame cause no tearing.

Parameters:
- COLS, 10, grid columns.
- ROWS, 20, grid rows.
- CELL_BITS, 3, bits per cell (colour index, 0 = empty).
- CELL_SHIFT, 4, log2 of cell size in pixels (16x16 cells).
- ORIGIN_X, 240, pixel x of grid left edge.
- ORIGIN_Y, 80, pixel y of grid top edge.
- BORDER_PX, 4, border thickness outside the grid rectangle.
- LINE_COLOR, 7, gridline colour index (optional feature only).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- grid_data  in  COLS*ROWS*CELL_BITS  flattened grid; cell i = bits [i*CELL_BITS +: CELL_BITS], i = row*COLS+col, row 0 = top.
- frame_start  in  1  one-cycle pulse at vblank start.
- pix_valid  in  1  pix_x/pix_y valid this cycle.
- pix_x  in  10  pixel column.
- pix_y  in  10  pixel row.
- cell_valid  out  1  pix_valid delayed 2 cycles.
- cell_color  out  CELL_BITS  colour index; 0 when not in_grid.
- in_grid  out  1  pixel lies inside the grid rectangle.
- border  out  1  pixel lies in the border ring.
- frames  out  8  frame_start counter.

Behaviour:
- Reset (reset==0 at an edge): snapshot, both pipeline stages, all outputs and frames cleared to 0. This takes priority over every other event, including mid-stream pixels and a coincident frame_start.
- Snapshot register:
  - Loaded from grid_data at every edge with frame_start=1; otherwise holds.
  - frames increments at the same edge, wrapping 255->0.
- Stage 1, at an edge with pix_valid sampled:
  - rx = pix_x-ORIGIN_X, ry = pix_y-ORIGIN_Y, both 11-bit signed.
  - in-grid when 0<=rx<COLS<<CELL_SHIFT and 0<=ry<ROWS<<CELL_SHIFT.
  - col = rx>>CELL_SHIFT, row = ry>>CELL_SHIFT.
  - index = row*COLS+col is registered; the multiply is by a constant.
  - border = not in-grid AND -BORDER_PX<=rx<(COLS<<CELL_SHIFT)+BORDER_PX AND the same test on ry.
  - The valid bit, in-grid flag, border flag and cell offsets are registered alongside the index.
- Stage 2, next edge:
  - cell_color = snapshot[index] if in-grid, else 0.
  - in_grid, border and cell_valid are registered from stage 1.
  - Total latency is exactly 2 edges, with one pixel accepted per cycle and no stalls.
- Invalid input: pix_valid=0 propagates as cell_valid=0. The other outputs are then 0.
- Coincident frame_start and pixel: a pixel sampled in the same cycle as frame_start reads the new snapshot. A pixel sampled one cycle earlier reads the old snapshot.
- grid_data changes without frame_start have no effect on the outputs.
- in_grid and border are never both 1.
- Coordinates 1023 and 0 must not alias into the grid; the signed arithmetic is required for this.

Optional Feature:
- Macro: GRID_LINES_EN.
- Defined: for in_grid pixels whose within-cell x offset or y offset is 0, and whose cell value is 0, cell_color = LINE_COLOR.
- Undefined: cell_color is always the raw snapshot value, and the offset bits are not carried into stage 2.

Test Plan:
- Reset, then grid_data cell 0 = 5, cell 199 = 3, pulse frame_start, then pixels (240,80) and (399,399) -> two cycles later cell_valid=1, in_grid=1, colours 5 then 3, border=0; frames=1.
- Pixels (238,100), (405,200) and (100,100) -> first gives border=1, in_grid=0, color=0; second and third give border=0, in_grid=0, color=0; cell_valid=1 for all three.
- Change cell 0 to 2 without frame_start, send (240,80) -> color still 5. Pulse frame_start in the same cycle as a pixel at (245,85) -> color 2.
- Continuous pix_valid over 20 pixels crossing x=255->256 -> colour changes exactly at the cell boundary, 2-cycle latency, no gaps. Pulse frame_start 256 times -> frames wraps to 0.
- Drive reset=0 for one cycle mid-stream with pix_valid=1 -> at the next edge all outputs 0 and frames=0; a pixel at (240,80) then returns color 0 (snapshot cleared).
- With GRID_LINES_EN and cell 1 empty: (256,80) -> color 7; (257,81) -> color 0. Without the macro: (256,80) -> color 0.

Source files
------------

// File: rtl/grid_scan_reader.sv
// grid_scan_reader: display-side reader of the playfield buffer.
// Snapshots the flattened grid at frame start, then maps each pixel
// coordinate to a cell colour, in-grid flag and border flag with a fixed
// two-cycle latency (one pixel per cycle, no stalls).
// Optional macro GRID_LINES_EN: paint empty in-grid pixels on a cell's
// first row/column with LINE_COLOR.
module grid_scan_reader #(
    parameter int COLS       = 10,
    parameter int ROWS       = 20,
    parameter int CELL_BITS  = 3,
    parameter int CELL_SHIFT = 4,
    parameter int ORIGIN_X   = 240,
    parameter int ORIGIN_Y   = 80,
    parameter int BORDER_PX  = 4,
    parameter int LINE_COLOR = 7
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [COLS*ROWS*CELL_BITS-1:0] grid_data,
    input  logic                           frame_start,
    input  logic                           pix_valid,
    input  logic [9:0]                     pix_x,
    input  logic [9:0]                     pix_y,
    output logic                           cell_valid,
    output logic [CELL_BITS-1:0]           cell_color,
    output logic                           in_grid,
    output logic                           border,
    output logic [7:0]                     frames
);
    localparam int STAGES = 2;
    localparam int NCELLS = COLS * ROWS;
    localparam int IDX_W  = $clog2(NCELLS);
    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS);

    // 11-bit signed bounds so coordinates left/above the origin go negative
    // instead of wrapping into the grid.
    localparam logic signed [10:0] OX  = 11'(ORIGIN_X);
    localparam logic signed [10:0] OY  = 11'(ORIGIN_Y);
    localparam logic signed [10:0] GW  = 11'(COLS << CELL_SHIFT);
    localparam logic signed [10:0] GH  = 11'(ROWS << CELL_SHIFT);
    localparam logic signed [10:0] BLO = -11'(BORDER_PX);
    localparam logic signed [10:0] BWX = 11'((COLS << CELL_SHIFT) + BORDER_PX);
    localparam logic signed [10:0] BWY = 11'((ROWS << CELL_SHIFT) + BORDER_PX);

    typedef struct packed {
        logic             in_grid;
        logic             border;
        logic [IDX_W-1:0] idx;
`ifdef GRID_LINES_EN
        logic [CELL_SHIFT-1:0] offx;
        logic [CELL_SHIFT-1:0] offy;
`endif
    } s1_t;

    logic [NCELLS*CELL_BITS-1:0] snap;
    logic [STAGES:1]             vld_pipe;
    s1_t                         s1_q, s1_d;
    logic signed [10:0]          rx, ry;
    logic                        ig_c, bd_c;
    logic [COL_W-1:0]            col_c;
    logic [ROW_W-1:0]            row_c;
    logic [CELL_BITS-1:0]        cell_raw, color_d;

    assign rx    = $signed({1'b0, pix_x}) - OX;
    assign ry    = $signed({1'b0, pix_y}) - OY;
    assign col_c = rx[CELL_SHIFT +: COL_W];
    assign row_c = ry[CELL_SHIFT +: ROW_W];

    // Stage 1 decode: region flags and constant-multiply cell index.
    always_comb begin
        ig_c = (rx >= 11'sd0) && (rx < GW) && (ry >= 11'sd0) && (ry < GH);
        bd_c = !ig_c && (rx >= BLO) && (rx < BWX) && (ry >= BLO) && (ry < BWY);
        s1_d = '0;
        if (pix_valid) begin
            s1_d.in_grid = ig_c;
            s1_d.border  = bd_c;
            if (ig_c)
                s1_d.idx = IDX_W'(row_c * COLS) + IDX_W'(col_c);
`ifdef GRID_LINES_EN
            s1_d.offx = rx[CELL_SHIFT-1:0];
            s1_d.offy = ry[CELL_SHIFT-1:0];
`endif
        end
    end

    assign cell_raw = snap[s1_q.idx * CELL_BITS +: CELL_BITS];

    // Stage 2 colour select from the frame snapshot.
    always_comb begin
        color_d = '0;
        if (s1_q.in_grid) begin
            color_d = cell_raw;
`ifdef GRID_LINES_EN
            if (cell_raw == '0 && (s1_q.offx == '0 || s1_q.offy == '0))
                color_d = CELL_BITS'(LINE_COLOR);
`endif
        end
    end

    // Snapshot and frame counter update on the vblank pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            snap   <= '0;
            frames <= '0;
        end else if (frame_start) begin
            snap   <= grid_data;
            frames <= frames + 8'd1;
        end
    end

    // Two-stage pixel pipeline; invalid slots carry all-zero payload.
    always_ff @(posedge clock) begin
        if (!reset) begin
            vld_pipe   <= '0;
            s1_q       <= '0;
            cell_color <= '0;
            in_grid    <= 1'b0;
            border     <= 1'b0;
        end else begin
            vld_pipe   <= {vld_pipe[STAGES-1:1], pix_valid};
            s1_q       <= s1_d;
            cell_color <= color_d;
            in_grid    <= s1_q.in_grid;
            border     <= s1_q.border;
        end
    end

    assign cell_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_grid_scan_reader.sv
// Bench for grid_scan_reader: directed vector table, hand-written corner
// sequences and random traffic checked every cycle against a
// coordinate-arithmetic reference model.
module tb_grid_scan_reader;
    logic         clock = 1'b0;
    logic         reset, frame_start, pix_valid;
    logic [9:0]   pix_x, pix_y;
    logic [599:0] grid_data;
    logic         cell_valid, in_grid, border;
    logic [2:0]   cell_color;
    logic [7:0]   frames;

    int total = 0;
    int bad   = 0;

    grid_scan_reader dut (
        .clock(clock), .reset(reset), .grid_data(grid_data),
        .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .cell_valid(cell_valid),
        .cell_color(cell_color), .in_grid(in_grid), .border(border),
        .frames(frames)
    );

    always #5 clock = ~clock;

`ifdef GRID_LINES_EN
    localparam bit LINES = 1'b1;
`else
    localparam bit LINES = 1'b0;
`endif

    typedef struct { int v; int c; int ig; int b; } exp_t;
    typedef struct { int x; int y; int color; int ig; int bd; } vec_t;

    int   m_snap[200];
    int   m_frames;
    exp_t m_s1, m_s2;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_pix(input bit v, input int x, input int y);
        exp_t e;
        int rx, ry;
        bit ig;
        e = '{0, 0, 0, 0};
        if (!v) return e;
        rx = x - 240;
        ry = y - 80;
        ig = rx >= 0 && rx < 160 && ry >= 0 && ry < 320;
        e.v  = 1;
        e.ig = ig;
        e.b  = (!ig && rx >= -4 && rx < 164 && ry >= -4 && ry < 324) ? 1 : 0;
        if (ig) begin
            e.c = m_snap[(ry / 16) * 10 + rx / 16];
            if (LINES && e.c == 0 && (rx % 16 == 0 || ry % 16 == 0)) e.c = 7;
        end
        return e;
    endfunction

    // One clock edge: advance the model with the sampled inputs, then check.
    task automatic tick();
        @(posedge clock);
        if (!reset) begin
            foreach (m_snap[i]) m_snap[i] = 0;
            m_frames = 0;
            m_s1 = '{0, 0, 0, 0};
            m_s2 = '{0, 0, 0, 0};
        end else begin
            m_s2 = m_s1;
            if (frame_start) begin
                foreach (m_snap[i]) m_snap[i] = int'(grid_data[i*3 +: 3]);
                m_frames = (m_frames + 1) % 256;
            end
            m_s1 = model_pix(pix_valid, int'(pix_x), int'(pix_y));
        end
        #1;
        chk("m_valid",  int'(cell_valid), m_s2.v);
        chk("m_color",  int'(cell_color), m_s2.c);
        chk("m_ingrid", int'(in_grid),    m_s2.ig);
        chk("m_border", int'(border),     m_s2.b);
        chk("m_frames", int'(frames),     m_frames);
        chk("excl", int'(in_grid & border), 0);
    endtask

    task automatic set_cell(input int i, input int v);
        grid_data[i*3 +: 3] = 3'(v);
    endtask

    task automatic pix(input int x, input int y);
        pix_valid = 1'b1;
        pix_x = 10'(x);
        pix_y = 10'(y);
    endtask

    task automatic idle();
        pix_valid = 1'b0;
        pix_x = '0;
        pix_y = '0;
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{240,  80, 5, 1, 0};
        tbl[1]  = '{399, 399, 3, 1, 0};
        tbl[2]  = '{238, 100, 0, 0, 1};
        tbl[3]  = '{405, 200, 0, 0, 0};
        tbl[4]  = '{100, 100, 0, 0, 0};
        tbl[5]  = '{1023, 1023, 0, 0, 0};
        tbl[6]  = '{0,     0, 0, 0, 0};
        tbl[7]  = '{236,  80, 0, 0, 1};
        tbl[8]  = '{235,  80, 0, 0, 0};
        tbl[9]  = '{403,  80, 0, 0, 1};
        tbl[10] = '{404,  80, 0, 0, 0};
        tbl[11] = '{300, 400, 0, 0, 1};

        foreach (m_snap[i]) m_snap[i] = 0;
        m_frames = 0;
        m_s1 = '{0, 0, 0, 0};
        m_s2 = '{0, 0, 0, 0};
        reset = 1'b0; frame_start = 1'b0; grid_data = '0;
        idle();
        repeat (3) tick();
        chk("rst_valid", int'(cell_valid), 0);
        chk("rst_frames", int'(frames), 0);
        reset = 1'b1;
        tick();

        // Load snapshot, then directed vector table.
        set_cell(0, 5);
        set_cell(199, 3);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            pix(tbl[k].x, tbl[k].y); tick();
            idle(); tick();
            chk("tbl_valid",  int'(cell_valid), 1);
            chk("tbl_color",  int'(cell_color), tbl[k].color);
            chk("tbl_ingrid", int'(in_grid),    tbl[k].ig);
            chk("tbl_border", int'(border),     tbl[k].bd);
        end
        chk("frames_one", int'(frames), 1);

        // grid_data change without frame_start is invisible.
        set_cell(0, 2);
        pix(240, 80); tick(); idle(); tick();
        chk("nofs_color", int'(cell_color), 5);
        // Pixel coincident with frame_start reads the new snapshot.
        frame_start = 1'b1; pix(245, 85); tick();
        frame_start = 1'b0; idle(); tick();
        chk("cofs_color", int'(cell_color), 2);

        // Back-to-back stream across the x=255/256 cell boundary.
        set_cell(1, 6);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        for (int k = 0; k < 22; k++) begin
            if (k < 20) pix(246 + k, 80); else idle();
            tick();
            if (k >= 1 && k <= 20) begin
                chk("strm_valid", int'(cell_valid), 1);
                chk("strm_color", int'(cell_color), (246 + k - 1 < 256) ? 2 : 6);
            end
        end

        // Frame counter wrap: three pulses so far, 253 more lands on 0.
        frame_start = 1'b1;
        repeat (253) tick();
        frame_start = 1'b0;
        tick();
        chk("frames_wrap", int'(frames), 0);

        // Mid-stream reset with a valid pixel present.
        pix(240, 80); tick();
        reset = 1'b0; tick();
        chk("mrst_valid",  int'(cell_valid), 0);
        chk("mrst_color",  int'(cell_color), 0);
        chk("mrst_ingrid", int'(in_grid),    0);
        chk("mrst_frames", int'(frames),     0);
        reset = 1'b1;
        tick(); idle(); tick();
        chk("mrst_snap_valid",  int'(cell_valid), 1);
        chk("mrst_snap_color",  int'(cell_color), 0);
        chk("mrst_snap_ingrid", int'(in_grid),    1);

        // Gridline pixels over an empty cell.
        set_cell(1, 0);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        pix(256, 80); tick();
        pix(257, 81); tick();
        chk("line_color0", int'(cell_color), LINES ? 7 : 0);
        idle(); tick();
        chk("line_color1", int'(cell_color), 0);

        // Random traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(0, 99) != 0);
            frame_start = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) set_cell($urandom_range(0, 199), $urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) idle();
            else if ($urandom_range(0, 5) == 0) pix($urandom_range(0, 1023), $urandom_range(0, 1023));
            else pix($urandom_range(220, 420), $urandom_range(60, 420));
            tick();
        end
        reset = 1'b1; frame_start = 1'b0; idle();
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
